shift_reg_ctrl: RTL and testbench

//  Sequencer for the parallel-load / serial-shift register (Ldn, Sh, Di, D[], Q[] interface).
//  - Accepts a parallel word on a start request and loads it into the register.
//  - Shifts the word out LSB-first (Di enters at the MSB, Q0 leaves), then reports completion.
//  - Sits between a word producer and the register instance; owns every register control pin.

---
 rtl/shift_reg_ctrl.sv | 123 ++++++++++++
 tb/tb_shift_reg_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_ctrl.sv
// Load/shift sequencer for a parallel-load, serial-shift register.
// Define PARITY_EN to append an even-parity bit after the shifted word.
module shift_reg_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    input  logic             abort,
    input  logic             q0,
    output logic             Ldn,
    output logic             Sh,
    output logic             Di,
    output logic [WIDTH-1:0] D,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StPar,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               fill_q, fill_d;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            count_q <= '0;
            word_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        word_d    = word_q;
        fill_d    = fill_q;
        Ldn       = 1'b1;
        Sh        = 1'b0;
        Di        = 1'b0;
        D         = '0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    word_d  = din;
                    fill_d  = fill;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                Ldn     = 1'b0;
                D       = word_q;
                busy    = 1'b1;
                count_d = '0;
                state_d = StShift;
            end
            StShift: begin
                Sh        = 1'b1;
                Di        = fill_q;
                D         = word_q;
                ser_valid = 1'b1;
                ser_out   = q0;
                busy      = 1'b1;
                count_d   = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_EN
                    state_d = StPar;
`else
                    state_d = StDone;
`endif
                end
            end
            StPar: begin
`ifdef PARITY_EN
                D         = word_q;
                ser_valid = 1'b1;
                ser_out   = ^word_q;
                busy      = 1'b1;
                state_d   = StDone;
`else
                state_d   = StIdle;
`endif
            end
            StDone: begin
                done    = 1'b1;
                busy    = 1'b1;
                D       = word_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl with a behavioural model of the attached register.
module tb_shift_reg_ctrl;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif
    localparam logic [10:0] RST_OUTS = 11'h400;

    logic         clk = 1'b0;
    logic         clrn = 1'b0;
    logic         start = 1'b0;
    logic         fill = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] din = '0;
    logic         q0;
    logic         Ldn, Sh, Di, ser_out, ser_valid, busy, done;
    logic [W-1:0] D;
    logic [W-1:0] sreg;
    logic         overlap_seen = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] din;
        logic       fill;
        int         gcyc;
        logic [3:0] gdin;
        logic [3:0] exp_ser;
        logic [3:0] exp_q;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    shift_reg_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .start    (start),
        .din      (din),
        .fill     (fill),
        .abort    (abort),
        .q0       (q0),
        .Ldn      (Ldn),
        .Sh       (Sh),
        .Di       (Di),
        .D        (D),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // External register: not reset by clrn, contents survive abort/reset.
    assign q0 = sreg[0];
    always @(posedge clk) begin
        if (!Ldn) sreg <= D;
        else if (Sh) sreg <= {Di, sreg[W-1:1]};
    end

    always @(negedge clk) begin
        if (!Ldn && Sh) overlap_seen <= 1'b1;
    end

    function automatic logic [10:0] outs();
        return {Ldn, Sh, Di, D, ser_out, ser_valid, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_seq(input string nm, input logic [3:0] w, input logic f, input int gcyc,
                           input logic [3:0] gdin, input logic [3:0] exp_ser,
                           input logic [3:0] exp_q, input logic exp_par);
        int cyc, ld_cnt, sh_cnt, sv_cnt, done_cyc;
        logic [3:0] ld_d, bits;
        logic par_seen, par_bit;
        ld_cnt = 0; sh_cnt = 0; sv_cnt = 0; done_cyc = -1;
        ld_d = '0; bits = '0; par_seen = 1'b0; par_bit = 1'b0;
        @(negedge clk);
        check({nm, "_idle_before"}, 32'(busy), 32'd0);
        start = 1'b1; din = w; fill = f; cyc = 0;
        while (cyc < 20 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == gcyc);
            if (cyc == gcyc) din = gdin;
            if (!Ldn) begin ld_cnt++; ld_d = D; end
            if (Sh) begin
                if (sh_cnt < 4) bits[sh_cnt] = ser_out;
                if (ser_valid) sv_cnt++;
                sh_cnt++;
            end
            if (ser_valid && !Sh) begin par_seen = 1'b1; par_bit = ser_out; end
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        check({nm, "_ld_cnt"}, 32'(ld_cnt), 32'd1);
        check({nm, "_ld_d"}, 32'(ld_d), 32'(w));
        check({nm, "_sh_cnt"}, 32'(sh_cnt), 32'd4);
        check({nm, "_sv_cnt"}, 32'(sv_cnt), 32'd4);
        check({nm, "_ser_bits"}, 32'(bits), 32'(exp_ser));
        check({nm, "_latency"}, 32'(done_cyc), 32'(LAT));
        check({nm, "_reg_q"}, 32'(sreg), 32'(exp_q));
`ifdef PARITY_EN
        check({nm, "_par_seen"}, 32'(par_seen), 32'd1);
        check({nm, "_par_bit"}, 32'(par_bit), 32'(exp_par));
`else
        check({nm, "_no_par"}, 32'(par_seen), 32'd0);
`endif
        @(negedge clk);
        check({nm, "_idle_after"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int cyc, d1, d2, loads;
        logic [3:0] load_d[0:3];
        logic [3:0] bits2;
        logic done_seen;

        // din, fill, glitch cycle, glitch din, serial bits (bit i = i-th out), final Q, parity
        vecs[0] = '{4'b0110, 1'b1, -1, 4'b0000, 4'b0110, 4'b1111, 1'b0};
        vecs[1] = '{4'b1001, 1'b0, -1, 4'b0000, 4'b1001, 4'b0000, 1'b0};
        vecs[2] = '{4'b1111, 1'b0, -1, 4'b0000, 4'b1111, 4'b0000, 1'b0};
        vecs[3] = '{4'b0000, 1'b1, -1, 4'b0000, 4'b0000, 4'b1111, 1'b0};
        vecs[4] = '{4'b0111, 1'b0, -1, 4'b0000, 4'b0111, 4'b0000, 1'b1};
        vecs[5] = '{4'b0110, 1'b1, 3, 4'b1001, 4'b0110, 4'b1111, 1'b0};

        #2;
        check("reset_outs", 32'(outs()), 32'(RST_OUTS));
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check("idle_outs", 32'(outs()), 32'(RST_OUTS));

        for (int i = 0; i < 6; i++) begin
            run_seq($sformatf("v%0d", i), vecs[i].din, vecs[i].fill, vecs[i].gcyc,
                    vecs[i].gdin, vecs[i].exp_ser, vecs[i].exp_q, vecs[i].exp_par);
        end

        // Abort in the second SHIFT cycle
        @(negedge clk);
        start = 1'b1; din = 4'b0110; fill = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_shift", 32'(Sh), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        check("abort_idle_outs", 32'(outs()), 32'(RST_OUTS));
        abort = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || busy) done_seen = 1'b1;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_reg_kept", 32'(sreg), 32'(4'b1101));

        // abort beats start in IDLE
        abort = 1'b1; start = 1'b1; din = 4'b1111;
        @(negedge clk);
        check("abort_prio", 32'(outs()), 32'(RST_OUTS));
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_prio_noq", 32'(outs()), 32'(RST_OUTS));

        // Reset during SHIFT
        start = 1'b1; din = 4'b0110; fill = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_shift", 32'(Sh), 32'd1);
        #1 clrn = 1'b0;
        #1 check("rst_async_outs", 32'(outs()), 32'(RST_OUTS));
        @(negedge clk);
        check("rst_held_outs", 32'(outs()), 32'(RST_OUTS));
        clrn = 1'b1;
        run_seq("rst_recover", 4'b1010, 1'b0, -1, 4'b0000, 4'b1010, 4'b0000, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; din = 4'b0011; fill = 1'b0;
        cyc = 0; d1 = -1; d2 = -1; loads = 0; bits2 = '0;
        for (int k = 0; k < 4; k++) load_d[k] = '0;
        while (cyc < 30 && d2 < 0) begin
            @(negedge clk);
            cyc++;
            if (Sh && loads == 2 && cyc >= 9 && cyc <= 12) bits2[cyc-9] = ser_out;
            if (!Ldn) begin
                if (loads < 4) load_d[loads] = D;
                loads++;
                if (loads == 1) din = 4'b1100;
                if (loads == 2) start = 1'b0;
            end
            if (done) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
        end
        start = 1'b0;
        check("b2b_first_lat", 32'(d1), 32'(LAT));
        check("b2b_period", 32'(d2 - d1), 32'(LAT + 1));
        check("b2b_loads", 32'(loads), 32'd2);
        check("b2b_load0", 32'(load_d[0]), 32'(4'b0011));
        check("b2b_load1", 32'(load_d[1]), 32'(4'b1100));
        check("b2b_bits2", 32'(bits2), 32'(4'b1100));
        check("b2b_reg_q", 32'(sreg), 32'(4'b0000));
        @(negedge clk);
        check("b2b_idle_after", 32'(busy), 32'd0);

        check("no_ldn_sh_overlap", 32'(overlap_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
